// File: rtl/mm_pkg.sv
// Shared types for the matrix-multiply load path.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2
    } b_load_state_t;

    // Selects one of the two B buffers (ping/pong).
    typedef logic buf_idx_t;

endpackage

// File: rtl/pingpong_owner.sv
// Tracks which B buffer is being filled and which buffers are owned by compute.
module pingpong_owner
    import mm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       set_i,
    input  logic [1:0] rd_release_i,
    output buf_idx_t   buf_sel_o,
    output logic [1:0] buf_full_o
);

    buf_idx_t   sel_q, sel_d;
    logic [1:0] full_q, full_d;

    // Set and release never target the same buffer, so the order here is moot.
    always_comb begin
        sel_d  = sel_q;
        full_d = full_q & ~rd_release_i;
        if (set_i) begin
            full_d[sel_q] = 1'b1;
            sel_d         = ~sel_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q  <= 1'b0;
            full_q <= 2'b00;
        end else begin
            sel_q  <= sel_d;
            full_q <= full_d;
        end
    end

    assign buf_sel_o  = sel_q;
    assign buf_full_o = full_q;

endmodule

// File: rtl/b_load_sched.sv
// Validates a B-matrix load request, clears the write-address generator, then
// forwards M2*M3 stream beats to the B banks with one cycle of latency.
module b_load_sched
    import mm_pkg::*;
#(
    parameter int N2           = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int DATA_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MATRIXSIZE_W-1:0] M2,
    input  logic [MATRIXSIZE_W-1:0] M3,
    output logic                    start_ready,
    output logic                    cfg_err,
    output logic                    busy,
    input  logic                    s_valid,
    input  logic [DATA_W-1:0]       s_data,
    output logic                    s_ready,
    output logic [MATRIXSIZE_W-1:0] M3dN2,
    output logic [MATRIXSIZE_W-1:0] M2_o,
    output logic                    wr_clr,
    output logic                    valid_B,
    output logic [DATA_W-1:0]       data_B,
    output logic                    buf_sel,
    output logic [1:0]              buf_full,
    input  logic [1:0]              rd_release,
    output logic                    load_done
);

    localparam int N2_LOG2 = $clog2(N2);
    localparam logic [MATRIXSIZE_W-1:0] ONE = MATRIXSIZE_W'(1);

    b_load_state_t           state_q, state_d;
    logic [MATRIXSIZE_W-1:0] row_q, row_d, col_q, col_d;
    logic [MATRIXSIZE_W-1:0] m2_q, m2_d, m3_q, m3_d, m3dn2_q, m3dn2_d;
    logic                    valid_q, valid_d, done_q, done_d, err_q, err_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    cfg_ok, col_wrap, last_beat;
    buf_idx_t                sel;

    assign cfg_ok    = (M2 != '0) && (M3 != '0) && (M3[N2_LOG2-1:0] == '0);
    assign col_wrap  = (col_q == m3_q - ONE);
    assign last_beat = col_wrap && (row_q == m2_q - ONE);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        m2_d    = m2_q;
        m3_d    = m3_q;
        m3dn2_d = m3dn2_q;
        valid_d = 1'b0;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && start_ready) begin
                    if (cfg_ok) begin
                        m2_d    = M2;
                        m3_d    = M3;
                        m3dn2_d = M3 >> N2_LOG2;
                        state_d = CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                row_d   = '0;
                col_d   = '0;
                state_d = LOAD;
            end
            LOAD: begin
                if (s_valid) begin
                    valid_d = 1'b1;
                    data_d  = s_data;
                    if (col_wrap) begin
                        col_d = '0;
                        row_d = row_q + ONE;
                    end else begin
                        col_d = col_q + ONE;
                    end
                    if (last_beat) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            m2_q    <= '0;
            m3_q    <= '0;
            m3dn2_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            m2_q    <= m2_d;
            m3_q    <= m3_d;
            m3dn2_q <= m3dn2_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Flags flip on the same edge that registers the final valid_B/load_done.
    pingpong_owner u_owner (
        .clk          (clk),
        .rst          (rst),
        .set_i        (done_d),
        .rd_release_i (rd_release),
        .buf_sel_o    (sel),
        .buf_full_o   (buf_full)
    );

    assign buf_sel     = sel;
    assign start_ready = (state_q == IDLE) && !buf_full[sel];
    assign busy        = (state_q != IDLE);
    assign s_ready     = (state_q == LOAD);
    assign wr_clr      = (state_q == CLEAR);
    assign valid_B     = valid_q;
    assign data_B      = data_q;
    assign load_done   = done_q;
    assign cfg_err     = err_q;
    assign M3dN2       = m3dn2_q;
    assign M2_o        = m2_q;

endmodule

// File: tb/tb_b_load_sched.sv
// Directed bench for b_load_sched: config table plus hand-written load sequences.
module tb_b_load_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] M2 = '0, M3 = '0;
    logic        start_ready, cfg_err, busy, s_ready, wr_clr, valid_B, buf_sel, load_done;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0, data_B;
    logic [15:0] M3dN2, M2_o;
    logic [1:0]  buf_full;
    logic [1:0]  rd_release = 2'b00;

    int total = 0;
    int bad   = 0;

    b_load_sched #(.N2(4), .MATRIXSIZE_W(16), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .M2(M2), .M3(M3),
        .start_ready(start_ready), .cfg_err(cfg_err), .busy(busy),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .M3dN2(M3dN2), .M2_o(M2_o), .wr_clr(wr_clr), .valid_B(valid_B),
        .data_B(data_B), .buf_sel(buf_sel), .buf_full(buf_full),
        .rd_release(rd_release), .load_done(load_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] m2;
        logic [15:0] m3;
        logic        exp_err;
    } cfg_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_wr_clr", 32'(wr_clr), 0);
        chk("rst_valid_B", 32'(valid_B), 0);
        chk("rst_load_done", 32'(load_done), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_data_B", 32'(data_B), 0);
        chk("rst_buf_sel", 32'(buf_sel), 0);
        chk("rst_buf_full", 32'(buf_full), 0);
        chk("rst_M3dN2", 32'(M3dN2), 0);
        chk("rst_M2_o", 32'(M2_o), 0);
        chk("rst_start_ready", 32'(start_ready), 1);
    endtask

    // Issue a valid start and step to LOAD, checking the CLEAR cycle.
    task automatic do_start(input logic [15:0] m2, input logic [15:0] m3);
        start = 1'b1; M2 = m2; M3 = m3;
        @(negedge clk);
        start = 1'b0;
        chk("clear_wr_clr", 32'(wr_clr), 1);
        chk("clear_busy", 32'(busy), 1);
        chk("clear_s_ready", 32'(s_ready), 0);
        @(negedge clk);
        chk("load_wr_clr", 32'(wr_clr), 0);
        chk("load_s_ready", 32'(s_ready), 1);
    endtask

    // Feed n beats base, base+1, ...; stall=1 inserts an idle cycle before each beat.
    task automatic load_seq(input int n, input bit stall, input logic [7:0] base,
                            input logic [1:0] rel_at_last);
        int  sent = 0;
        int  cyc  = 0;
        int  pulses = 0;
        bit  drv;
        logic [7:0] d;
        while (sent < n && cyc < 200) begin
            drv = stall ? (cyc % 2 == 1) : 1'b1;
            d   = base + 8'(sent);
            chk("ld_s_ready", 32'(s_ready), 1);
            s_valid    = drv;
            s_data     = drv ? d : 8'hEE;
            rd_release = (drv && sent == n - 1) ? rel_at_last : 2'b00;
            @(negedge clk);
            s_valid    = 1'b0;
            rd_release = 2'b00;
            chk("ld_valid_B", 32'(valid_B), 32'(drv));
            if (drv) begin
                pulses++;
                chk("ld_data_B", 32'(data_B), 32'(d));
                chk("ld_load_done", 32'(load_done), 32'(sent == n - 1));
                sent++;
            end
            cyc++;
        end
        chk("ld_budget", 32'(sent), 32'(n));
        chk("ld_pulses", 32'(pulses), 32'(n));
        chk("ld_idle_busy", 32'(busy), 0);
        @(negedge clk);
        chk("ld_after_valid_B", 32'(valid_B), 0);
        chk("ld_after_done", 32'(load_done), 0);
    endtask

    cfg_vec_t vecs[3];

    initial begin
        vecs[0] = '{m2: 16'd2, m3: 16'd6, exp_err: 1'b1};
        vecs[1] = '{m2: 16'd0, m3: 16'd4, exp_err: 1'b1};
        vecs[2] = '{m2: 16'd3, m3: 16'd0, exp_err: 1'b1};

        // Reset state
        @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();

        // Rejected configurations
        foreach (vecs[i]) begin
            start = 1'b1; M2 = vecs[i].m2; M3 = vecs[i].m3;
            @(negedge clk);
            start = 1'b0;
            chk("cfg_err_pulse", 32'(cfg_err), 32'(vecs[i].exp_err));
            chk("cfg_busy", 32'(busy), 0);
            chk("cfg_wr_clr", 32'(wr_clr), 0);
            @(negedge clk);
            chk("cfg_err_clear", 32'(cfg_err), 0);
            chk("cfg_busy2", 32'(busy), 0);
            chk("cfg_start_ready", 32'(start_ready), 1);
        end

        // Basic load into buffer 0
        do_start(16'd2, 16'd4);
        load_seq(8, 1'b0, 8'd1, 2'b00);
        chk("basic_buf_full", 32'(buf_full), 32'h1);
        chk("basic_buf_sel", 32'(buf_sel), 1);
        chk("basic_M3dN2", 32'(M3dN2), 1);
        chk("basic_M2_o", 32'(M2_o), 2);
        chk("basic_start_ready", 32'(start_ready), 1);

        // Stalled load into buffer 1 fills both buffers
        do_start(16'd2, 16'd4);
        load_seq(8, 1'b1, 8'h21, 2'b00);
        chk("bp_buf_full", 32'(buf_full), 32'h3);
        chk("bp_start_ready", 32'(start_ready), 0);
        start = 1'b1; M2 = 16'd2; M3 = 16'd4;
        @(negedge clk);
        start = 1'b0;
        chk("bp_ignored_busy", 32'(busy), 0);
        chk("bp_ignored_wr_clr", 32'(wr_clr), 0);
        chk("bp_ignored_err", 32'(cfg_err), 0);
        rd_release = 2'b01;
        @(negedge clk);
        rd_release = 2'b00;
        chk("bp_rel_buf_full", 32'(buf_full), 32'h2);
        chk("bp_rel_start_ready", 32'(start_ready), 1);

        // Load finishing into buffer 1 while buffer 0 is released
        rd_release = 2'b10;
        @(negedge clk);
        rd_release = 2'b00;
        chk("sim_pre_full", 32'(buf_full), 0);
        do_start(16'd1, 16'd4);
        load_seq(4, 1'b0, 8'h40, 2'b00);
        chk("sim_mid_full", 32'(buf_full), 32'h1);
        chk("sim_mid_sel", 32'(buf_sel), 1);
        do_start(16'd1, 16'd8);
        chk("sim_M3dN2", 32'(M3dN2), 2);
        load_seq(8, 1'b0, 8'h50, 2'b01);
        chk("sim_buf_full", 32'(buf_full), 32'h2);
        chk("sim_buf_sel", 32'(buf_sel), 0);

        // Reset in the middle of a load
        do_start(16'd2, 16'd4);
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = 8'(8'h60 + k);
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("mid_valid_B", 32'(valid_B), 1);
        rst = 1'b1;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        do_start(16'd2, 16'd4);
        load_seq(8, 1'b0, 8'h70, 2'b00);
        chk("post_rst_buf_full", 32'(buf_full), 32'h1);
        chk("post_rst_buf_sel", 32'(buf_sel), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
